// File: rtl/chacha_block_ctrl.sv
// ChaCha block engine: loads the 16-word state from key/counter/nonce,
// runs one column or diagonal round per clock on four quarter-round
// units, adds the initial state back and presents the 512-bit block
// on a valid/ready interface.

// One ChaCha quarter-round (a, b, c, d), purely combinational.
module chacha_quarterround (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  logic [31:0] a1, b1, c1, d1;

  assign a1  = a_i + b_i;
  assign d1  = rotl(d_i ^ a1, 16);
  assign c1  = c_i + d1;
  assign b1  = rotl(b_i ^ c1, 12);
  assign a_o = a1 + b1;
  assign d_o = rotl(d1 ^ a_o, 8);
  assign c_o = c1 + d_o;
  assign b_o = rotl(b1 ^ c_o, 7);

endmodule

module chacha_block_ctrl #(
  parameter int DOUBLE_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         busy,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [511:0] keystream
);

  localparam logic [4:0] LAST_RC = 5'(2 * DOUBLE_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_e;

  state_e       state_q, state_d;
  logic [4:0]   rc_q;
  logic [31:0]  init_q  [16];
  logic [31:0]  work_q  [16];
  logic [31:0]  init_w  [16];
  logic [31:0]  work_d  [16];
  logic [511:0] keystream_q;

  logic [31:0]  qa [4], qb [4], qc [4], qd [4];
  logic [31:0]  ra [4], rb [4], rc [4], rd [4];

  // State word index for operand r (0=a..3=d) of quarter-round unit j.
  // Column rounds use column j; diagonal rounds shift row r by r columns.
  function automatic logic [3:0] qr_idx(input logic diag, input logic [1:0] j,
                                        input logic [1:0] r);
    logic [1:0] col;
    col = diag ? j + r : j;
    return {r, col};
  endfunction

  // Initial state assembled from constants and the request inputs.
  always_comb begin
    init_w[0] = 32'h61707865;
    init_w[1] = 32'h3320646e;
    init_w[2] = 32'h79622d32;
    init_w[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) init_w[4 + i] = key[32*i +: 32];
    init_w[12] = counter;
    for (int i = 0; i < 3; i++) init_w[13 + i] = nonce[32*i +: 32];
  end

  // Route working-state words to the four quarter-round units.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      qa[j] = work_q[qr_idx(rc_q[0], 2'(j), 2'd0)];
      qb[j] = work_q[qr_idx(rc_q[0], 2'(j), 2'd1)];
      qc[j] = work_q[qr_idx(rc_q[0], 2'(j), 2'd2)];
      qd[j] = work_q[qr_idx(rc_q[0], 2'(j), 2'd3)];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_quarterround u_qr (
      .a_i(qa[g]), .b_i(qb[g]), .c_i(qc[g]), .d_i(qd[g]),
      .a_o(ra[g]), .b_o(rb[g]), .c_o(rc[g]), .d_o(rd[g])
    );
  end

  // Scatter the quarter-round results back into their state positions.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    work_d = work_q;
    for (int j = 0; j < 4; j++) begin
      work_d[qr_idx(rc_q[0], 2'(j), 2'd0)] = ra[j];
      work_d[qr_idx(rc_q[0], 2'(j), 2'd1)] = rb[j];
      work_d[qr_idx(rc_q[0], 2'(j), 2'd2)] = rc[j];
      work_d[qr_idx(rc_q[0], 2'(j), 2'd3)] = rd[j];
    end
  end

  // Next-state logic of the block sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ROUND;
      ROUND:   if (rc_q == LAST_RC) state_d = FINAL;
      FINAL:   state_d = OUT;
      OUT:     if (ks_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: state capture, round updates, feed-forward into the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q        <= '0;
      keystream_q <= '0;
      // NOTE: the state arrays are reset too because reset must clear
      // every trace of a partially computed block, not just the control.
      for (int i = 0; i < 16; i++) begin
        init_q[i] <= '0;
        work_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          init_q <= init_w;
          work_q <= init_w;
          rc_q   <= '0;
        end
        ROUND: begin
          work_q <= work_d;
          rc_q   <= rc_q + 5'd1;
        end
        FINAL: for (int i = 0; i < 16; i++)
          keystream_q[32*i +: 32] <= work_q[i] + init_q[i];
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign ks_valid  = (state_q == OUT);
  assign keystream = keystream_q;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Randomised and directed bench for chacha_block_ctrl against a
// straightforward array-based ChaCha block model.
module tb_chacha_block_ctrl;

  localparam int DR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key;
  logic [31:0]  counter;
  logic [95:0]  nonce;
  logic         busy;
  logic         ks_valid;
  logic         ks_ready;
  logic [511:0] keystream;

  int n_tests = 0;
  int n_fail  = 0;

  int qtab [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                      '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  chacha_block_ctrl #(.DOUBLE_ROUNDS(DR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .counter(counter),
    .nonce(nonce), .busy(busy), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .keystream(keystream)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int r);
    return (v << r) | (v >> (32 - r));
  endfunction

  // Reference ChaCha block: 2*DR rounds of the quarter-round table, then feed-forward.
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c,
                                             input logic [95:0] n);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] out;
    int ia, ib, ic, id;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
    x = s;
    for (int dr = 0; dr < DR; dr++) begin
      for (int q = 0; q < 8; q++) begin
        ia = qtab[q][0]; ib = qtab[q][1]; ic = qtab[q][2]; id = qtab[q][3];
        x[ia] = x[ia] + x[ib]; x[id] = rotl32(x[id] ^ x[ia], 16);
        x[ic] = x[ic] + x[id]; x[ib] = rotl32(x[ib] ^ x[ic], 12);
        x[ia] = x[ia] + x[ib]; x[id] = rotl32(x[id] ^ x[ia], 8);
        x[ic] = x[ic] + x[id]; x[ib] = rotl32(x[ib] ^ x[ic], 7);
      end
    end
    for (int i = 0; i < 16; i++) out[32*i +: 32] = x[i] + s[i];
    return out;
  endfunction

  // One request: start at E0, optional stall in OUT, handshake, back in IDLE.
  // glitch: zero the key before E3, pulse start (counter=7) at E5 and
  // hold start high through OUT including the handshake edge.
  task automatic do_block(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n,
                          input int stall, input bit glitch, output logic [511:0] ks);
    int cnt;
    key = k; counter = c; nonce = n;
    start = 1'b1;
    ks_ready = (stall == 0);
    tick();
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    cnt = 0;
    while (!ks_valid && cnt < 200) begin
      if (glitch && cnt == 2) key = '0;
      if (glitch && cnt == 4) begin start = 1'b1; counter = 32'd7; end
      if (glitch && cnt == 5) start = 1'b0;
      tick();
      cnt++;
    end
    check("valid_latency", cnt, 2 * DR + 1);
    ks = keystream;
    check("block", ks, ref_block(k, c, n));
    check("busy_in_out", busy, 1'b1);
    for (int s = 0; s < stall; s++) begin
      if (glitch) start = 1'b1;
      tick();
      check("stall_valid", ks_valid, 1'b1);
      check("stall_data", keystream, ks);
    end
    ks_ready = 1'b1;
    tick();
    start = 1'b0;
    ks_ready = 1'b0;
    check("hs_valid_low", ks_valid, 1'b0);
    check("hs_busy_low", busy, 1'b0);
    check("hs_data_kept", keystream, ks);
    if (glitch) begin
      tick();
      check("no_second_valid", ks_valid, 1'b0);
      check("no_second_busy", busy, 1'b0);
    end
  endtask

  logic [255:0] kat_key;
  logic [95:0]  kat_nonce;
  logic [511:0] ks1, ks2, ks3;
  logic [255:0] rk;
  logic [95:0]  rn;
  logic [31:0]  rc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; key = '0; counter = '0; nonce = '0; ks_ready = 1'b0;
    for (int i = 0; i < 32; i++) kat_key[8*i +: 8] = 8'(i);
    kat_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", ks_valid, 1'b0);
    check("rst_ks", keystream, '0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_busy", busy, 1'b0);
      check("idle_valid", ks_valid, 1'b0);
      check("idle_ks", keystream, '0);
    end

    // Known-answer vector, ks_ready held high.
    do_block(kat_key, 32'd1, kat_nonce, 0, 1'b0, ks1);
    check("kat_w0", ks1[31:0], 32'he4e7f110);
    check("kat_w1", ks1[63:32], 32'h15593bd1);
    check("kat_w15", ks1[511:480], 32'h4e3c50a2);

    // Back-to-back: counter=2 accepted on the edge right after the handshake.
    do_block(kat_key, 32'd2, kat_nonce, 0, 1'b0, ks2);
    check("ctr2_w0_differs", (ks2[31:0] != ks1[31:0]), 1'b1);

    // Backpressure: 30 stalled cycles in OUT.
    do_block(kat_key, 32'd1, kat_nonce, 30, 1'b0, ks3);
    check("bp_same_as_kat", ks3, ks1);

    // Input changes and start pulses while busy are ignored.
    do_block(kat_key, 32'd1, kat_nonce, 3, 1'b1, ks3);
    check("glitch_same_as_kat", ks3, ks1);

    // Reset in the middle of the rounds discards the block.
    key = kat_key; counter = 32'd1; nonce = kat_nonce;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", ks_valid, 1'b0);
    check("midrst_ks", keystream, '0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("midrst_no_stale", ks_valid, 1'b0);
    end
    do_block(kat_key, 32'd1, kat_nonce, 0, 1'b0, ks3);
    check("midrst_fresh", ks3, ks1);

    // Randomised requests, including the all-ones counter.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom;
      for (int i = 0; i < 3; i++) rn[32*i +: 32] = $urandom;
      rc = (t == 0) ? 32'hffffffff : $urandom;
      do_block(rk, rc, rn, int'($urandom_range(0, 4)), 1'b0, ks3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
